// File: rtl/pred_regfile_2w2r_pkg.sv
// Shared constants for the predicate register file: which entry is the
// hardwired TRUE predicate, the value other entries reset/clear to, and default sizes.
package pred_pkg;
  localparam int   PRED_TRUE_IDX  = 0;
  localparam logic PRED_RESET_VAL = 1'b0;
  localparam int   DEFAULT_NPRED  = 16;
  localparam int   DEFAULT_IDXW   = 4;
endpackage

// File: rtl/pred_regfile_2w2r_if.sv
// Bundle between a cmpp-style predicate producer/consumer and the predicate register file.
interface pred_regfile_2w2r_if
  import pred_pkg::*;
#(
  parameter int NPRED = DEFAULT_NPRED,
  parameter int IDXW  = DEFAULT_IDXW
) ();
  // No valid/ready pair here: each write port is qualified only by its wrN_en,
  // and stall=1 drops that cycle's writes/clr, so a producer must hold them until stall=0.
  logic             stall;
  logic             clr;
  logic             wr0_en;
  logic [IDXW-1:0]  wr0_idx;
  logic             wr0_data;
  logic             wr1_en;
  logic [IDXW-1:0]  wr1_idx;
  logic             wr1_data;
  logic [IDXW-1:0]  rd0_idx;
  logic             rd0_data;
  logic [IDXW-1:0]  rd1_idx;
  logic             rd1_data;
  logic [NPRED-1:0] pred_vec;

  modport master (
    output stall, clr, wr0_en, wr0_idx, wr0_data, wr1_en, wr1_idx, wr1_data,
           rd0_idx, rd1_idx,
    input  rd0_data, rd1_data, pred_vec
  );

  modport slave (
    input  stall, clr, wr0_en, wr0_idx, wr0_data, wr1_en, wr1_idx, wr1_data,
           rd0_idx, rd1_idx,
    output rd0_data, rd1_data, pred_vec
  );
endinterface

// File: rtl/pred_regfile_2w2r_next_state.sv
// Next value of every predicate entry: clr beats writes, port 1 beats port 0
// on a shared index, and the TRUE entry is never touched.
module pred_next_state
  import pred_pkg::*;
#(
  parameter int NPRED = DEFAULT_NPRED,
  parameter int IDXW  = DEFAULT_IDXW
) (
  input  logic [NPRED-1:0] cur_i,
  input  logic             clr_i,
  input  logic             wr0_en_i,
  input  logic [IDXW-1:0]  wr0_idx_i,
  input  logic             wr0_data_i,
  input  logic             wr1_en_i,
  input  logic [IDXW-1:0]  wr1_idx_i,
  input  logic             wr1_data_i,
  output logic [NPRED-1:0] nxt_o
);
  always_comb begin
    nxt_o = cur_i;
    for (int i = 0; i < NPRED; i++) begin
      if (i != PRED_TRUE_IDX) begin
        if (clr_i) begin
          nxt_o[i] = PRED_RESET_VAL;
        end else begin
          // Port 1 is applied last so it wins a same-index collision.
          if (wr0_en_i && (int'(wr0_idx_i) == i)) nxt_o[i] = wr0_data_i;
          if (wr1_en_i && (int'(wr1_idx_i) == i)) nxt_o[i] = wr1_data_i;
        end
      end
    end
  end
endmodule

// File: rtl/pred_regfile_2w2r.sv
// Two-write, two-read predicate register file with registered read ports and a
// registered snapshot of all entries; entry 0 always reads TRUE.
module pred_regfile_2w2r
  import pred_pkg::*;
#(
  parameter int NPRED  = DEFAULT_NPRED,
  parameter int IDXW   = DEFAULT_IDXW,
  parameter int BYPASS = 1
) (
  input  logic                clk,
  input  logic                reset,
  pred_regfile_2w2r_if.slave  bus
);
  localparam logic [NPRED-1:0] RESET_VEC = {{(NPRED-1){PRED_RESET_VAL}}, 1'b1};

  logic [NPRED-1:0] entries_q, entries_d, view;
  logic [NPRED-1:0] pred_vec_q;
  logic             rd0_q, rd1_q;

  pred_next_state #(.NPRED(NPRED), .IDXW(IDXW)) u_next (
    .cur_i      (entries_q),
    .clr_i      (bus.clr),
    .wr0_en_i   (bus.wr0_en),
    .wr0_idx_i  (bus.wr0_idx),
    .wr0_data_i (bus.wr0_data),
    .wr1_en_i   (bus.wr1_en),
    .wr1_idx_i  (bus.wr1_idx),
    .wr1_data_i (bus.wr1_data),
    .nxt_o      (entries_d)
  );

  // Reads see the post-update array when bypassing, the current array otherwise.
  assign view = (BYPASS != 0) ? entries_d : entries_q;

  function automatic logic rd_sel(input logic [NPRED-1:0] v, input logic [IDXW-1:0] idx);
    return (int'(idx) < NPRED) ? v[idx] : 1'b0;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q  <= RESET_VEC;
      pred_vec_q <= RESET_VEC;
      rd0_q      <= 1'b1;
      rd1_q      <= 1'b1;
    end else if (!bus.stall) begin
      entries_q  <= entries_d;
      pred_vec_q <= view;
      rd0_q      <= rd_sel(view, bus.rd0_idx);
      rd1_q      <= rd_sel(view, bus.rd1_idx);
    end
  end

  assign bus.rd0_data = rd0_q;
  assign bus.rd1_data = rd1_q;
  assign bus.pred_vec = pred_vec_q;
endmodule

// File: tb/tb_pred_regfile_2w2r.sv
// Directed bench for the predicate register file: a bypassing and a non-bypassing
// instance see the same stimulus and are compared every cycle against a rule-level model.
module tb_pred_regfile_2w2r;
  localparam int NPRED = 16;
  localparam int IDXW  = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            stall = 0, clr = 0;
  logic            wr0_en = 0, wr0_data = 0, wr1_en = 0, wr1_data = 0;
  logic [IDXW-1:0] wr0_idx = '0, wr1_idx = '0, rd0_idx = '0, rd1_idx = '0;

  pred_regfile_2w2r_if #(.NPRED(NPRED), .IDXW(IDXW)) if_b ();
  pred_regfile_2w2r_if #(.NPRED(NPRED), .IDXW(IDXW)) if_n ();

  assign if_b.stall = stall;      assign if_n.stall = stall;
  assign if_b.clr = clr;          assign if_n.clr = clr;
  assign if_b.wr0_en = wr0_en;    assign if_n.wr0_en = wr0_en;
  assign if_b.wr0_idx = wr0_idx;  assign if_n.wr0_idx = wr0_idx;
  assign if_b.wr0_data = wr0_data; assign if_n.wr0_data = wr0_data;
  assign if_b.wr1_en = wr1_en;    assign if_n.wr1_en = wr1_en;
  assign if_b.wr1_idx = wr1_idx;  assign if_n.wr1_idx = wr1_idx;
  assign if_b.wr1_data = wr1_data; assign if_n.wr1_data = wr1_data;
  assign if_b.rd0_idx = rd0_idx;  assign if_n.rd0_idx = rd0_idx;
  assign if_b.rd1_idx = rd1_idx;  assign if_n.rd1_idx = rd1_idx;

  pred_regfile_2w2r #(.NPRED(NPRED), .IDXW(IDXW), .BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .bus(if_b));
  pred_regfile_2w2r #(.NPRED(NPRED), .IDXW(IDXW), .BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .bus(if_n));

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit   m_ent[NPRED];
  bit   m_new[NPRED];
  bit   model_valid = 0;
  bit   e_rd0_b, e_rd1_b, e_rd0_n, e_rd1_n;
  logic [15:0] e_vec_b, e_vec_n;

  function automatic bit peek(input bit e[NPRED], input int idx);
    if (idx >= NPRED) return 1'b0;
    if (idx == 0) return 1'b1;
    return e[idx];
  endfunction

  function automatic logic [15:0] pack(input bit e[NPRED]);
    logic [15:0] v = '0;
    for (int i = 0; i < NPRED; i++) v[i] = (i == 0) ? 1'b1 : e[i];
    return v;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NPRED; i++) m_ent[i] = (i == 0);
      e_rd0_b = 1; e_rd1_b = 1; e_rd0_n = 1; e_rd1_n = 1;
      e_vec_b = 16'h0001; e_vec_n = 16'h0001;
      model_valid = 1;
    end else if (!stall) begin
      m_new = m_ent;
      if (clr) begin
        for (int i = 1; i < NPRED; i++) m_new[i] = 0;
      end else begin
        if (wr0_en && wr0_idx != 0 && int'(wr0_idx) < NPRED) m_new[wr0_idx] = wr0_data;
        if (wr1_en && wr1_idx != 0 && int'(wr1_idx) < NPRED) m_new[wr1_idx] = wr1_data;
      end
      e_rd0_b = peek(m_new, int'(rd0_idx));
      e_rd1_b = peek(m_new, int'(rd1_idx));
      e_rd0_n = peek(m_ent, int'(rd0_idx));
      e_rd1_n = peek(m_ent, int'(rd1_idx));
      e_vec_b = pack(m_new);
      e_vec_n = pack(m_ent);
      m_ent = m_new;
    end
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_rd0_byp", {15'b0, if_b.rd0_data}, {15'b0, e_rd0_b});
      chk("model_rd1_byp", {15'b0, if_b.rd1_data}, {15'b0, e_rd1_b});
      chk("model_vec_byp", if_b.pred_vec, e_vec_b);
      chk("model_rd0_nobyp", {15'b0, if_n.rd0_data}, {15'b0, e_rd0_n});
      chk("model_rd1_nobyp", {15'b0, if_n.rd1_data}, {15'b0, e_rd1_n});
      chk("model_vec_nobyp", if_n.pred_vec, e_vec_n);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr_off();
    wr0_en = 0; wr1_en = 0; clr = 0;
  endtask

  task automatic set_wr0(input int idx, input bit d);
    wr0_en = 1; wr0_idx = IDXW'(idx); wr0_data = d;
  endtask

  task automatic set_wr1(input int idx, input bit d);
    wr1_en = 1; wr1_idx = IDXW'(idx); wr1_data = d;
  endtask

  // Literal expectations checked on both instances.
  task automatic lit_both(input string name, input bit rd0, input bit rd1, input logic [15:0] vec);
    chk({name, "_rd0_byp"}, {15'b0, if_b.rd0_data}, {15'b0, rd0});
    chk({name, "_rd1_byp"}, {15'b0, if_b.rd1_data}, {15'b0, rd1});
    chk({name, "_vec_byp"}, if_b.pred_vec, vec);
    chk({name, "_rd0_nobyp"}, {15'b0, if_n.rd0_data}, {15'b0, rd0});
    chk({name, "_rd1_nobyp"}, {15'b0, if_n.rd1_data}, {15'b0, rd1});
    chk({name, "_vec_nobyp"}, if_n.pred_vec, vec);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset for two cycles, then one read cycle of entries 0 and 5.
    reset = 1; rd0_idx = 0; rd1_idx = 5;
    tick(); tick();
    lit_both("reset_vals", 1, 1, 16'h0001);
    reset = 0;
    tick();
    lit_both("reset_read", 1, 0, 16'h0001);

    // Write 3 and 7, read them back.
    set_wr0(3, 1); set_wr1(7, 1); rd0_idx = 3; rd1_idx = 7;
    tick();
    chk("wr_bypass_vec", if_b.pred_vec, 16'h0089);
    chk("wr_nobypass_vec", if_n.pred_vec, 16'h0001);
    wr_off();
    tick();
    lit_both("wr_read", 1, 1, 16'h0089);

    // Collision on entry 4: port 1 (data 0) wins.
    set_wr0(4, 1); set_wr1(4, 0); rd0_idx = 4;
    tick();
    chk("coll_bypass_rd0", {15'b0, if_b.rd0_data}, 16'h0000);
    wr_off(); set_wr0(4, 1);
    tick();
    chk("set4_bypass_rd0", {15'b0, if_b.rd0_data}, 16'h0001);
    wr_off(); set_wr0(4, 1); set_wr1(4, 0);
    tick();
    chk("coll_nobypass_old", {15'b0, if_n.rd0_data}, 16'h0001);
    chk("coll_bypass_new", {15'b0, if_b.rd0_data}, 16'h0000);
    wr_off();
    tick();
    chk("coll_nobypass_new", {15'b0, if_n.rd0_data}, 16'h0000);

    // Entry 0 ignores writes.
    set_wr0(0, 0); rd0_idx = 0;
    tick();
    lit_both("idx0_protect", 1, 1, 16'h0089);
    wr_off();
    tick();
    chk("idx0_vec_bit0", {15'b0, if_n.pred_vec[0]}, 16'h0001);

    // clr beats a same-cycle write.
    clr = 1; set_wr0(2, 1);
    tick();
    chk("clr_bypass_vec", if_b.pred_vec, 16'h0001);
    wr_off();
    tick();
    lit_both("clr_after", 1, 0, 16'h0001);

    // Stall drops writes and freezes outputs.
    set_wr0(3, 1); rd1_idx = 3;
    tick();
    wr_off();
    tick();
    lit_both("pre_stall", 1, 1, 16'h0009);
    stall = 1; set_wr0(9, 1); rd0_idx = 9; rd1_idx = 5;
    tick();
    lit_both("stall_hold1", 1, 1, 16'h0009);
    tick();
    lit_both("stall_hold2", 1, 1, 16'h0009);
    stall = 0; wr_off();
    tick();
    lit_both("stall_lost", 0, 0, 16'h0009);

    // Reset beats active writes.
    reset = 1; set_wr0(5, 1); set_wr1(6, 1); rd0_idx = 0; rd1_idx = 5;
    tick();
    lit_both("midop_reset", 1, 1, 16'h0001);
    reset = 0; wr_off();
    tick();
    lit_both("midop_reset_read", 1, 0, 16'h0001);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
